// File: rtl/fpro_uart_bus_master.sv
// UART byte-stream initiator for the FPro MMIO bus: decodes 'W'/'R' commands from the
// RX FIFO, issues one single-cycle bus access and answers through the TX FIFO.
module fpro_uart_bus_master #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  rx_data,
    output logic        rd_uart,
    input  logic        tx_full,
    output logic [7:0]  tx_data,
    output logic        wr_uart,
    output logic        fp_mmio_cs,
    output logic        fp_wr,
    output logic        fp_rd,
    output logic [20:0] fp_addr,
    output logic [31:0] fp_wr_data,
    input  logic [31:0] fp_rd_data,
    output logic        busy,
    output logic        timeout_err
);
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] BUS_WR = 3'd3;
    localparam logic [2:0] BUS_RD = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;
    localparam logic [2:0] ACK    = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    logic [2:0]       state;
    logic [1:0]       cnt;
    logic             is_wr;
    logic [20:0]      addr_q;
    logic [23:0]      data_sh;
    logic [31:0]      rdata;
    logic [TMO_W-1:0] tmo_cnt;
    logic             pop;
    logic             push;

    // Pop is gated by reset so nothing leaves the RX FIFO while reset is held.
    assign pop  = (state == IDLE || state == ADDR || state == DATA) && !rx_empty && !reset;
    assign push = (state == RESP || state == ACK || state == ERR) && !tx_full;

    always_comb begin
        rd_uart    = pop;
        wr_uart    = push;
        fp_wr      = (state == BUS_WR);
        fp_rd      = (state == BUS_RD);
        fp_mmio_cs = fp_wr | fp_rd;
        busy       = (state != IDLE);
        case (state)
            RESP:    tx_data = rdata[31:24];
            ACK:     tx_data = 8'h4B;
            ERR:     tx_data = 8'h3F;
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            is_wr       <= 1'b0;
            addr_q      <= '0;
            data_sh     <= '0;
            rdata       <= '0;
            tmo_cnt     <= '0;
            fp_addr     <= '0;
            fp_wr_data  <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (rx_data == 8'h57 || rx_data == 8'h52) begin
                            is_wr   <= (rx_data == 8'h57);
                            cnt     <= 2'd0;
                            tmo_cnt <= '0;
                            state   <= ADDR;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                ADDR: begin
                    if (pop) begin
                        // 21-bit shift register: the top 3 bits of the 24-bit address fall off.
                        addr_q  <= {addr_q[12:0], rx_data};
                        tmo_cnt <= '0;
                        cnt     <= cnt + 2'd1;
                        if (cnt == 2'd2) begin
                            cnt <= 2'd0;
                            if (is_wr) begin
                                state <= DATA;
                            end else begin
                                fp_addr <= {addr_q[12:0], rx_data};
                                state   <= BUS_RD;
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (pop) begin
                        data_sh <= {data_sh[15:0], rx_data};
                        tmo_cnt <= '0;
                        cnt     <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            fp_addr    <= addr_q;
                            fp_wr_data <= {data_sh, rx_data};
                            state      <= BUS_WR;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                BUS_WR: state <= ACK;
                BUS_RD: begin
                    rdata <= fp_rd_data;
                    cnt   <= 2'd0;
                    state <= RESP;
                end
                RESP: begin
                    if (push) begin
                        rdata <= {rdata[23:0], 8'h00};
                        cnt   <= cnt + 2'd1;
                        if (cnt == 2'd3) state <= IDLE;
                    end
                end
                ACK, ERR: begin
                    if (push) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpro_uart_bus_master.sv
// Directed bench for fpro_uart_bus_master: models the RX FIFO as a queue and logs every
// bus strobe and TX byte, then checks them against hand-computed values.
module tb_fpro_uart_bus_master;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_full = 1'b0;
    logic [31:0] fp_rd_data = 32'h0;
    logic        rd_uart, wr_uart, fp_mmio_cs, fp_wr, fp_rd, busy, timeout_err;
    logic [7:0]  tx_data;
    logic [20:0] fp_addr;
    logic [31:0] fp_wr_data;

    fpro_uart_bus_master #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .tx_data(tx_data), .wr_uart(wr_uart), .fp_mmio_cs(fp_mmio_cs),
        .fp_wr(fp_wr), .fp_rd(fp_rd), .fp_addr(fp_addr), .fp_wr_data(fp_wr_data),
        .fp_rd_data(fp_rd_data), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tcount = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int n_wr, n_rd, n_tmo, wr_tick, rd_tick, tmo_tick, last_pop_tick, first_tx_tick;
    int viol = 0;
    logic [20:0] s_addr;
    logic [31:0] s_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_rx();
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        refresh_rx();
    endtask

    task automatic clear_log();
        n_wr = 0; n_rd = 0; n_tmo = 0;
        wr_tick = -1; rd_tick = -1; tmo_tick = -1; last_pop_tick = -1; first_tx_tick = -1;
        txq.delete();
    endtask

    // One clock: sample outputs at the falling edge, then apply the FIFO pop after the rise.
    task automatic tick();
        logic popped;
        @(negedge clk);
        tcount++;
        popped = rd_uart;
        if (rd_uart && rx_empty) viol++;
        if (wr_uart && tx_full) viol++;
        if (fp_wr && fp_rd) viol++;
        if (fp_mmio_cs !== (fp_wr | fp_rd)) viol++;
        if (rd_uart) last_pop_tick = tcount;
        if (wr_uart) begin
            txq.push_back(tx_data);
            if (first_tx_tick < 0) first_tx_tick = tcount;
        end
        if (fp_wr) begin n_wr++; wr_tick = tcount; s_addr = fp_addr; s_wdata = fp_wr_data; end
        if (fp_rd) begin n_rd++; rd_tick = tcount; s_addr = fp_addr; end
        if (timeout_err) begin n_tmo++; tmo_tick = tcount; end
        @(posedge clk);
        #1;
        if (popped && rxq.size() > 0) rxq.delete(0);
        refresh_rx();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((rxq.size() != 0 || busy) && n < budget);
        check("reached_idle", 32'(busy), 0);
    endtask

    function automatic logic [31:0] txword();
        if (txq.size() == 4) return {txq[0], txq[1], txq[2], txq[3]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] txbyte0();
        if (txq.size() > 0) return 32'(txq[0]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int hold_bad;
        clear_log();
        reset = 1'b1;
        refresh_rx();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 32'({busy, rd_uart, wr_uart, fp_mmio_cs, fp_wr, fp_rd, timeout_err}), 0);
        check("reset_tx_data", 32'(tx_data), 0);
        check("reset_addr", 32'(fp_addr), 0);
        check("reset_wdata", fp_wr_data, 0);
        reset = 1'b0;
        tick();
        tick();

        // Write: 57 00 00 21 DE AD BE EF
        clear_log();
        push(8'h57); push(8'h00); push(8'h00); push(8'h21);
        push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
        run_idle(40);
        check("wr_strobes", n_wr, 1);
        check("wr_no_rd", n_rd, 0);
        check("wr_addr", 32'(s_addr), 32'h21);
        check("wr_data", s_wdata, 32'hDEADBEEF);
        check("wr_tx_count", txq.size(), 1);
        check("wr_ack", txbyte0(), 32'h4B);
        check("wr_strobe_latency", wr_tick - last_pop_tick, 1);
        check("wr_ack_latency", first_tx_tick - wr_tick, 1);
        check("wr_addr_hold", 32'(fp_addr), 32'h21);
        check("wr_data_hold", fp_wr_data, 32'hDEADBEEF);

        // Read with TX backpressure: 52 1F FF FF
        clear_log();
        fp_rd_data = 32'h12345678;
        push(8'h52); push(8'h1F); push(8'hFF); push(8'hFF);
        n = 0;
        while (n_rd == 0 && n < 20) begin tick(); n++; end
        check("rd_strobes", n_rd, 1);
        check("rd_addr", 32'(s_addr), 32'h1FFFFF);
        check("rd_strobe_latency", rd_tick - last_pop_tick, 1);
        tx_full = 1'b1;
        fp_rd_data = 32'hFFFF_FFFF;
        hold_bad = 0;
        repeat (20) begin
            tick();
            if (tx_data !== 8'h12) hold_bad++;
        end
        check("bp_no_write", txq.size(), 0);
        check("bp_tx_hold", hold_bad, 0);
        tx_full = 1'b0;
        run_idle(20);
        check("rd_resp", txword(), 32'h12345678);
        check("rd_no_wr", n_wr, 0);

        // Unknown opcode, then a valid read
        clear_log();
        push(8'h41);
        run_idle(10);
        check("bad_tx_count", txq.size(), 1);
        check("bad_resp", txbyte0(), 32'h3F);
        check("bad_no_strobe", n_wr + n_rd, 0);
        clear_log();
        fp_rd_data = 32'hA5C30F81;
        push(8'h52); push(8'h00); push(8'h00); push(8'h05);
        run_idle(20);
        check("after_bad_addr", 32'(s_addr), 32'h5);
        check("after_bad_resp", txword(), 32'hA5C30F81);

        // Timeout: 57 00 then silence; pulse registered 16 edges after the last pop edge
        clear_log();
        push(8'h57); push(8'h00);
        n = 0;
        while (n_tmo == 0 && n < 40) begin tick(); n++; end
        check("tmo_pulses", n_tmo, 1);
        check("tmo_delay", tmo_tick - last_pop_tick, 17);
        tick();
        tick();
        check("tmo_single_cycle", n_tmo, 1);
        check("tmo_idle", 32'(busy), 0);
        check("tmo_no_strobe", n_wr + n_rd, 0);
        check("tmo_no_tx", txq.size(), 0);
        clear_log();
        fp_rd_data = 32'h0BADF00D;
        push(8'h52); push(8'h00); push(8'h00); push(8'h07);
        run_idle(20);
        check("after_tmo_addr", 32'(s_addr), 32'h7);
        check("after_tmo_resp", txword(), 32'h0BADF00D);

        // Async reset in DATA after two data bytes
        clear_log();
        push(8'h57); push(8'h00); push(8'h00); push(8'h10); push(8'hAA); push(8'hBB);
        n = 0;
        while (rxq.size() != 0 && n < 20) begin tick(); n++; end
        check("pre_reset_busy", 32'(busy), 1);
        push(8'hCC);
        reset = 1'b1;
        #1;
        check("arst_ctrl", 32'({busy, rd_uart, wr_uart, fp_mmio_cs, fp_wr, fp_rd, timeout_err}), 0);
        check("arst_addr", 32'(fp_addr), 0);
        check("arst_tx_data", 32'(tx_data), 0);
        rxq.delete();
        refresh_rx();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_log();
        repeat (10) tick();
        check("arst_no_strobe", n_wr + n_rd, 0);
        check("arst_no_tx", txq.size(), 0);
        check("arst_idle", 32'(busy), 0);
        check("protocol_violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpro_uart_bus_master.md
Name: fpro_uart_bus_master

Overview:
- Byte-stream initiator on the FPro MMIO bus. It lets a host PC reach MMIO slots over UART without the MicroBlaze MCS.
- Consumes command bytes from a UART receive FIFO, issues single-cycle FPro read/write transactions, and returns results through the UART transmit FIFO.
- Sits in place of, or muxed against, the MCS bridge as a second bus initiator. The FPro responder side, mmio_sys, is unchanged.

Parameters:
- TIMEOUT_CYC, 1_000_000, max idle cycles between bytes of one command before abort (10 ms at 100 MHz); legal range >= 2.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- rx_empty  input  1  RX FIFO empty; rx_data valid whenever 0 (first-word fall-through)
- rx_data  input  8  RX FIFO head byte
- rd_uart  output  1  pop RX FIFO, one-cycle pulse
- tx_full  input  1  TX FIFO full
- tx_data  output  8  byte to transmit
- wr_uart  output  1  push tx_data into TX FIFO, one-cycle pulse
- fp_mmio_cs  output  1  MMIO chip select, asserted with each strobe
- fp_wr  output  1  write strobe
- fp_rd  output  1  read strobe
- fp_addr  output  21  word address
- fp_wr_data  output  32  write data
- fp_rd_data  input  32  read data, valid during the fp_rd cycle
- busy  output  1  high in any state other than IDLE
- timeout_err  output  1  one-cycle pulse on command abort

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter, timeout counter, address and data registers cleared.
- Reset mid-operation discards the partial command. No bus strobe and no TX byte are issued after reset asserts.
- Command format:
  - Byte 0 is the opcode: 0x57 'W' (write) or 0x52 'R' (read).
  - Then 3 address bytes, MSB first. fp_addr takes bits [20:0] of the 24-bit value; the top 3 bits are ignored.
  - 'W' only: then 4 data bytes, MSB first.
- Byte consumption:
  - At most one byte per cycle.
  - rd_uart = 1 exactly in cycles where the state accepts a byte and rx_empty = 0. The byte is registered at that same edge.
  - rd_uart is never asserted while rx_empty = 1.
- States:
  - IDLE: on a byte, 'W'/'R' -> ADDR with cnt = 0. Any other byte -> ERR.
  - ADDR: shift in a byte per pop. After the 3rd byte, 'W' -> DATA with cnt = 0 and 'R' -> BUS_RD.
  - DATA: shift in 4 bytes, then -> BUS_WR.
  - BUS_WR: one cycle with fp_mmio_cs = fp_wr = 1 and fp_addr/fp_wr_data driven. -> ACK.
  - BUS_RD: one cycle with fp_mmio_cs = fp_rd = 1. fp_rd_data is captured at the end of this cycle. -> RESP with cnt = 0.
  - RESP: send the 4 captured bytes MSB first, one per cycle with tx_full = 0. After the 4th -> IDLE.
  - ACK: send 0x4B 'K' when tx_full = 0, -> IDLE.
  - ERR: send 0x3F '?' when tx_full = 0, -> IDLE.
- Strobes are exactly one cycle. fp_wr and fp_rd are never both high.
- fp_addr and fp_wr_data hold their last values outside strobes.
- Latency: last command byte popped at edge N -> strobe in cycle N+1 -> first response byte written in cycle N+2 if tx_full = 0.
- TX backpressure:
  - wr_uart = 1 only when tx_full = 0. Otherwise the FSM stalls with tx_data stable.
  - No timeout applies in RESP, ACK or ERR.
- Timeout:
  - The counter runs in ADDR/DATA while rx_empty = 1 and clears on every popped byte.
  - When it reaches TIMEOUT_CYC - 1: timeout_err pulses for one cycle and the state returns to IDLE. No bus access and no response byte.
- Unknown opcode byte: consumed, answered with '?'. No resynchronisation beyond returning to IDLE.
- A byte arriving while in BUS_*, RESP, ACK or ERR stays in the RX FIFO until the FSM returns to IDLE.

Test Plan:
- Write: RX bytes 57 00 00 21 DE AD BE EF back-to-back -> one cycle with fp_wr = 1, fp_addr = 0x00021, fp_wr_data = 0xDEADBEEF; then TX 0x4B; busy returns to 0.
- Read: RX 52 1F FF FF, responder returns 0x12345678 -> fp_rd one cycle, fp_addr = 0x1FFFFF (upper bits dropped); TX 12 34 56 78 in order.
- Backpressure: tx_full = 1 for 20 cycles during RESP -> wr_uart stays 0, tx_data holds 0x12; then the remaining bytes complete with no loss or duplication.
- Bad opcode: RX 0x41 -> single TX 0x3F; no bus strobe; next valid command works.
- Timeout with TIMEOUT_CYC = 16: RX 57 00 then silence -> timeout_err pulse 16 cycles after the last pop; no strobe; a following read completes normally.
- Async reset asserted in DATA after 2 data bytes -> outputs 0 immediately; no strobe or TX after release.
